// File: rtl/spi_word_ctrl.sv
// spi_word_ctrl: multi-byte transaction controller that feeds SPI_Master one byte per handshake.
// Optional per-byte watchdog is compiled in when SPI_CTRL_TIMEOUT_EN is defined.
module spi_word_ctrl #(
  parameter int WORD_BYTES   = 8,
  parameter int CS_LEAD_CLKS = 2,
  parameter int CS_GAP_CLKS  = 4,
  parameter int TIMEOUT_CLKS = 255
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic [8*WORD_BYTES-1:0]          i_TX_Word,
  input  logic [$clog2(WORD_BYTES+1)-1:0]  i_TX_Count,
  input  logic                             i_TX_DV,
  output logic                             o_TX_Ready,
  output logic [8*WORD_BYTES-1:0]          o_RX_Word,
  output logic                             o_RX_DV,
  output logic                             o_Timeout,
  output logic [7:0]                       o_M_TX_Byte,
  output logic                             o_M_TX_DV,
  input  logic                             i_M_TX_Ready,
  input  logic                             i_M_RX_DV,
  input  logic [7:0]                       i_M_RX_Byte,
  output logic                             o_SPI_CS_n
);

  localparam int W       = 8 * WORD_BYTES;
  localparam int CW      = $clog2(WORD_BYTES + 1);
  localparam int TMR_MAX = (CS_LEAD_CLKS > CS_GAP_CLKS) ? CS_LEAD_CLKS : CS_GAP_CLKS;
  localparam int TW      = $clog2(TMR_MAX + 1);

  localparam logic [TW-1:0] LEAD_LAST  = TW'(CS_LEAD_CLKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(CS_GAP_CLKS - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WORD_BYTES);

  if (WORD_BYTES < 2 || CS_LEAD_CLKS < 1 || CS_GAP_CLKS < 1 || TIMEOUT_CLKS < 1) begin : g_bad_params
    $error("spi_word_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, LEAD, ISSUE, WAIT_RX, WAIT_RDY, GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] n_sel, n_bytes, byte_cnt;
  logic [TW-1:0] tmr;
  logic [W-1:0]  shift_reg, load_word, rx_next;
  logic [W-9:0]  rx_acc;
  logic          accept, issue, rx_take, last_byte, wd_expired;

  // Out-of-range counts are treated like 0: a full word.
  always_comb begin
    n_sel     = (i_TX_Count == '0 || i_TX_Count > FULL_COUNT) ? FULL_COUNT : i_TX_Count;
    load_word = i_TX_Word << (8 * (WORD_BYTES - int'(n_sel)));
    rx_next   = {rx_acc, i_M_RX_Byte};
  end

  assign accept    = (state == IDLE)    && i_TX_DV;
  assign issue     = (state == ISSUE)   && i_M_TX_Ready;
  assign rx_take   = (state == WAIT_RX) && i_M_RX_DV;
  assign last_byte = (byte_cnt + 1'b1) == n_bytes;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (i_TX_DV)          state_next = LEAD;
      LEAD:     if (tmr == LEAD_LAST) state_next = ISSUE;
      ISSUE:    if (i_M_TX_Ready)     state_next = WAIT_RX;
      WAIT_RX: begin
        if (i_M_RX_DV)       state_next = last_byte ? GAP : WAIT_RDY;
        else if (wd_expired) state_next = GAP;
      end
      WAIT_RDY: if (i_M_TX_Ready)     state_next = ISSUE;
      GAP:      if (tmr == GAP_LAST)  state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_TX_Ready  <= 1'b1;
      o_SPI_CS_n  <= 1'b1;
      o_M_TX_DV   <= 1'b0;
      o_M_TX_Byte <= '0;
      o_RX_Word   <= '0;
      o_RX_DV     <= 1'b0;
      tmr         <= '0;
      n_bytes     <= '0;
      byte_cnt    <= '0;
    end else begin
      o_TX_Ready <= (state_next == IDLE);
      o_SPI_CS_n <= (state_next == IDLE) || (state_next == GAP);
      o_M_TX_DV  <= issue;
      o_RX_DV    <= 1'b0;

      if ((state_next == state) && (state == LEAD || state == GAP)) tmr <= tmr + 1'b1;
      else                                                          tmr <= '0;

      if (issue) o_M_TX_Byte <= shift_reg[W-1 -: 8];

      if (accept) begin
        n_bytes  <= n_sel;
        byte_cnt <= '0;
      end else if (rx_take) begin
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (rx_take && last_byte) begin
        o_RX_Word <= rx_next;
        o_RX_DV   <= 1'b1;
      end
    end
  end

  // NOTE: shift_reg and rx_acc are pure datapath, always loaded on accept before use, so they carry no reset.
  always_ff @(posedge i_Clk) begin
    if (accept) begin
      shift_reg <= load_word;
      rx_acc    <= '0;
    end else begin
      if (issue)   shift_reg <= shift_reg << 8;
      if (rx_take) rx_acc    <= rx_next[W-9:0];
    end
  end

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CLKS - 1);

  logic [WDW-1:0] wd_cnt;

  assign wd_expired = (wd_cnt == WD_LAST);

  // Restarted by each byte issue; only advances while waiting for the returned byte.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wd_cnt    <= '0;
      o_Timeout <= 1'b0;
    end else begin
      o_Timeout <= (state == WAIT_RX) && !i_M_RX_DV && wd_expired;
      if (issue || state != WAIT_RX) wd_cnt <= '0;
      else                           wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign o_Timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_ctrl.sv
// Self-checking bench for spi_word_ctrl: behavioural SPI_Master stand-in plus a word-level reference model.
`timescale 1ns/1ps
module tb_spi_word_ctrl;

  localparam int WB       = 8;
  localparam int LEAD_CLK = 2;
  localparam int GAP_CLK  = 4;
  localparam int TO_CLK   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tx_word;
  logic [3:0]  tx_count;
  logic        tx_dv;
  logic        tx_ready;
  logic [63:0] rx_word;
  logic        rx_dv;
  logic        timeout;
  logic [7:0]  m_tx_byte;
  logic        m_tx_dv;
  logic        m_tx_ready;
  logic        m_rx_dv;
  logic [7:0]  m_rx_byte;
  logic        cs_n;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  spi_word_ctrl #(
    .WORD_BYTES  (WB),
    .CS_LEAD_CLKS(LEAD_CLK),
    .CS_GAP_CLKS (GAP_CLK),
    .TIMEOUT_CLKS(TO_CLK)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_TX_Word   (tx_word),
    .i_TX_Count  (tx_count),
    .i_TX_DV     (tx_dv),
    .o_TX_Ready  (tx_ready),
    .o_RX_Word   (rx_word),
    .o_RX_DV     (rx_dv),
    .o_Timeout   (timeout),
    .o_M_TX_Byte (m_tx_byte),
    .o_M_TX_DV   (m_tx_dv),
    .i_M_TX_Ready(m_tx_ready),
    .i_M_RX_DV   (m_rx_dv),
    .i_M_RX_Byte (m_rx_byte),
    .o_SPI_CS_n  (cs_n)
  );

  // Master stand-in: accepts a byte, answers after a random latency, then re-arms ready.
  bit         stub_mode    = 1'b0;
  bit         loopback     = 1'b1;
  bit         master_abort = 1'b0;
  logic [7:0] resp_q[$];

  initial begin : master_model
    int         wait_cnt;
    int         post_cnt;
    bit         busy;
    logic [7:0] cur;
    busy = 1'b0; wait_cnt = 0; post_cnt = 0; cur = '0;
    m_tx_ready = 1'b1; m_rx_dv = 1'b0; m_rx_byte = '0;
    forever begin
      @(negedge clk);
      m_rx_dv = 1'b0;
      if (rst || master_abort) begin
        busy = 1'b0; m_tx_ready = 1'b1; post_cnt = 0;
      end else if (busy) begin
        if (wait_cnt > 0) wait_cnt--;
        else if (!stub_mode) begin
          m_rx_byte = loopback ? cur : 8'($urandom);
          m_rx_dv   = 1'b1;
          resp_q.push_back(m_rx_byte);
          busy      = 1'b0;
          post_cnt  = $urandom_range(0, 3);
        end
      end else if (m_tx_dv) begin
        busy = 1'b1; m_tx_ready = 1'b0; cur = m_tx_byte;
        wait_cnt = $urandom_range(2, 10);
      end else if (!m_tx_ready) begin
        if (post_cnt > 0) post_cnt--;
        else              m_tx_ready = 1'b1;
      end
    end
  end

  // Passive monitor of the DUT-side interface.
  logic [7:0] tx_seen[$];
  int rx_dv_cnt = 0, timeout_cnt = 0, cyc = 0, last_dv_cyc = 0, last_to_cyc = 0;
  int cs_high_run = 0, last_gap = 0, lead_run = 0, last_lead = 0;
  bit lead_armed = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (m_tx_dv) begin
        tx_seen.push_back(m_tx_byte);
        last_dv_cyc = cyc;
        if (lead_armed) begin last_lead = lead_run; lead_armed = 1'b0; end
      end
      if (rx_dv)   rx_dv_cnt++;
      if (timeout) begin timeout_cnt++; last_to_cyc = cyc; end
      if (cs_n === 1'b1) begin
        cs_high_run++;
        lead_armed = 1'b0;
      end else begin
        if (cs_high_run > 0) begin last_gap = cs_high_run; lead_run = 0; lead_armed = 1'b1; end
        cs_high_run = 0;
        if (lead_armed) lead_run++;
      end
    end
  end

  initial begin : time_guard
    #2ms;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    int guard;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 300) begin tick(); guard++; end
    ok = (tx_ready === 1'b1);
    compared++;
    if (!ok) begin
      $display("FAIL %s ready_wait: o_TX_Ready=%b required 1", tag, tx_ready);
      mismatched++;
    end
  endtask

  // One complete transaction, checked against the word-level model.
  task automatic run_word(input logic [63:0] w, input logic [3:0] c, input bit inject_busy,
                          input string tag, output logic [63:0] got);
    int          n, guard, rx0;
    bit          ok, cs_broke;
    logic [63:0] exp_rx;
    got = '0;
    n   = (c == 4'd0) ? WB : int'(c);
    wait_ready(tag, ok);
    if (!ok) return;
    tx_seen.delete(); resp_q.delete(); rx0 = rx_dv_cnt;
    tx_word = w; tx_count = c; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
    compared++;
    if (tx_ready !== 1'b0 || cs_n !== 1'b0) begin
      $display("FAIL %s accept: ready=%b cs_n=%b required 0/0", tag, tx_ready, cs_n);
      mismatched++;
    end
    cs_broke = 1'b0; guard = 0;
    while (rx_dv_cnt == rx0 && guard < 2000) begin
      if (cs_n !== 1'b0) cs_broke = 1'b1;
      if (inject_busy && guard == 5) begin tx_word = {8{8'hAA}}; tx_count = 4'd0; tx_dv = 1'b1; end
      else tx_dv = 1'b0;
      tick();
      guard++;
    end
    tx_dv = 1'b0;
    compared++;
    if (rx_dv_cnt != rx0 + 1) begin
      $display("FAIL %s rx_dv_wait: pulses=%0d required 1", tag, rx_dv_cnt - rx0);
      mismatched++;
      return;
    end
    compared++;
    if (cs_broke) begin
      $display("FAIL %s cs_continuous: CS went high mid-word, required low throughout", tag);
      mismatched++;
    end
    compared++;
    if (cs_n !== 1'b1) begin
      $display("FAIL %s cs_release: cs_n=%b required 1", tag, cs_n);
      mismatched++;
    end
    compared++;
    if (tx_seen.size() != n) begin
      $display("FAIL %s byte_count: issued=%0d required %0d", tag, tx_seen.size(), n);
      mismatched++;
    end
    for (int i = 0; i < n && i < tx_seen.size(); i++) begin
      compared++;
      if (tx_seen[i] !== w[8*(n-1-i) +: 8]) begin
        $display("FAIL %s tx_byte[%0d]: got %h required %h", tag, i, tx_seen[i], w[8*(n-1-i) +: 8]);
        mismatched++;
      end
    end
    exp_rx = '0;
    foreach (resp_q[i]) exp_rx = exp_rx * 64'd256 + 64'(resp_q[i]);
    compared++;
    if (rx_word !== exp_rx) begin
      $display("FAIL %s rx_word: got %h required %h", tag, rx_word, exp_rx);
      mismatched++;
    end
    got = rx_word;
    tick();
    compared++;
    if (rx_dv !== 1'b0 || rx_dv_cnt != rx0 + 1) begin
      $display("FAIL %s rx_dv_single: rx_dv=%b pulses=%0d required 0/1", tag, rx_dv, rx_dv_cnt - rx0);
      mismatched++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_dv = 1'b0; tx_word = '0; tx_count = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    compared++;
    if (tx_ready !== 1'b1 || cs_n !== 1'b1) begin
      $display("FAIL reset_ready_cs: ready=%b cs_n=%b required 1/1", tx_ready, cs_n);
      mismatched++;
    end
    compared++;
    if (m_tx_dv !== 1'b0 || m_tx_byte !== 8'h00) begin
      $display("FAIL reset_master_if: dv=%b byte=%h required 0/00", m_tx_dv, m_tx_byte);
      mismatched++;
    end
    compared++;
    if (rx_word !== 64'h0 || rx_dv !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL reset_rx: word=%h dv=%b timeout=%b required 0/0/0", rx_word, rx_dv, timeout);
      mismatched++;
    end
  endtask

  task automatic test_full_word();
    logic [63:0] got;
    run_word(64'h0123456789ABCDEF, 4'd8, 1'b0, "full_word", got);
    compared++;
    if (got !== 64'h0123456789ABCDEF) begin
      $display("FAIL full_word_const: got %h required 0123456789abcdef", got);
      mismatched++;
    end
    compared++;
    if (last_lead < LEAD_CLK) begin
      $display("FAIL cs_lead: %0d cycles required >= %0d", last_lead, LEAD_CLK);
      mismatched++;
    end
  endtask

  task automatic test_short_word();
    logic [63:0] got;
    run_word(64'hFFFFFFFFFFFFBEEF, 4'd2, 1'b0, "short_word", got);
    compared++;
    if (got !== 64'h000000000000BEEF) begin
      $display("FAIL short_word_const: got %h required 000000000000beef", got);
      mismatched++;
    end
  endtask

  task automatic test_count_zero();
    logic [63:0] got;
    run_word(64'hC1C2C3C4C5C6C7C8, 4'd0, 1'b0, "count_zero", got);
    compared++;
    if (got !== 64'hC1C2C3C4C5C6C7C8) begin
      $display("FAIL count_zero_const: got %h required c1c2c3c4c5c6c7c8", got);
      mismatched++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] got;
    int          n0;
    bit          ok;
    run_word(64'h1020304050607080, 4'd8, 1'b1, "busy_ignore", got);
    compared++;
    if (got !== 64'h1020304050607080) begin
      $display("FAIL busy_word: got %h required 1020304050607080", got);
      mismatched++;
    end
    wait_ready("busy_idle", ok);
    n0 = tx_seen.size();
    repeat (10) tick();
    compared++;
    if (cs_n !== 1'b1 || tx_seen.size() != n0) begin
      $display("FAIL busy_no_restart: cs_n=%b extra_bytes=%0d required 1/0", cs_n, tx_seen.size() - n0);
      mismatched++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got;
    run_word(64'h00000000DEADBEEF, 4'd4, 1'b0, "b2b_first", got);
    run_word(64'h0000000000C0FFEE, 4'd3, 1'b0, "b2b_second", got);
    compared++;
    if (got !== 64'h0000000000C0FFEE) begin
      $display("FAIL b2b_word: got %h required 0000000000c0ffee", got);
      mismatched++;
    end
    compared++;
    if (last_gap < GAP_CLK) begin
      $display("FAIL cs_gap: %0d cycles high required >= %0d", last_gap, GAP_CLK);
      mismatched++;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    int          guard, rx0;
    bit          ok;
    wait_ready("reset_mid", ok);
    if (!ok) return;
    tx_seen.delete(); rx0 = rx_dv_cnt;
    tx_word = 64'h1122334455667788; tx_count = 4'd8; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0; guard = 0;
    while (tx_seen.size() < 3 && guard < 2000) begin tick(); guard++; end
    compared++;
    if (tx_seen.size() < 3) begin
      $display("FAIL reset_mid_progress: bytes=%0d required 3", tx_seen.size());
      mismatched++;
    end
    rst = 1'b1;
    tick();
    compared++;
    if (cs_n !== 1'b1 || tx_ready !== 1'b1) begin
      $display("FAIL reset_mid_cs_ready: cs_n=%b ready=%b required 1/1", cs_n, tx_ready);
      mismatched++;
    end
    compared++;
    if (rx_dv !== 1'b0 || m_tx_dv !== 1'b0 || rx_word !== 64'h0) begin
      $display("FAIL reset_mid_outputs: rx_dv=%b m_dv=%b word=%h required 0/0/0", rx_dv, m_tx_dv, rx_word);
      mismatched++;
    end
    rst = 1'b0;
    repeat (30) tick();
    compared++;
    if (rx_dv_cnt != rx0 || cs_n !== 1'b1) begin
      $display("FAIL reset_mid_abandon: rx_pulses=%0d cs_n=%b required 0/1", rx_dv_cnt - rx0, cs_n);
      mismatched++;
    end
    run_word(64'h000000000000005A, 4'd1, 1'b0, "after_reset", got);
    compared++;
    if (got !== 64'h000000000000005A) begin
      $display("FAIL after_reset_const: got %h required 000000000000005a", got);
      mismatched++;
    end
  endtask

  task automatic test_random();
    logic [63:0] got, w;
    logic [3:0]  c;
    loopback = 1'b0;
    for (int k = 0; k < 25; k++) begin
      w = {$urandom, $urandom};
      c = 4'($urandom_range(0, 8));
      run_word(w, c, 1'b0, $sformatf("random_%0d", k), got);
    end
    loopback = 1'b1;
  endtask

`ifdef SPI_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [63:0] prev;
    int          guard, rx0, to0;
    bit          ok;
    wait_ready("timeout", ok);
    if (!ok) return;
    stub_mode = 1'b1;
    prev = rx_word; rx0 = rx_dv_cnt; to0 = timeout_cnt;
    tx_word = 64'h77; tx_count = 4'd1; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0; guard = 0;
    while (timeout_cnt == to0 && guard < 500) begin tick(); guard++; end
    compared++;
    if (timeout_cnt != to0 + 1) begin
      $display("FAIL timeout_seen: pulses=%0d required 1", timeout_cnt - to0);
      mismatched++;
    end else begin
      compared++;
      if (last_to_cyc - last_dv_cyc != TO_CLK) begin
        $display("FAIL timeout_latency: %0d cycles required %0d", last_to_cyc - last_dv_cyc, TO_CLK);
        mismatched++;
      end
      compared++;
      if (cs_n !== 1'b1 || rx_dv_cnt != rx0 || rx_word !== prev) begin
        $display("FAIL timeout_abort: cs_n=%b rx_pulses=%0d word=%h required 1/0/%h",
                 cs_n, rx_dv_cnt - rx0, rx_word, prev);
        mismatched++;
      end
      tick();
      compared++;
      if (timeout !== 1'b0) begin
        $display("FAIL timeout_single: o_Timeout=%b required 0", timeout);
        mismatched++;
      end
    end
    stub_mode = 1'b0; master_abort = 1'b1;
    tick();
    master_abort = 1'b0;
  endtask
`else
  task automatic test_timeout();
    compared++;
    if (timeout_cnt != 0 || timeout !== 1'b0) begin
      $display("FAIL timeout_disabled: pulses=%0d required 0", timeout_cnt);
      mismatched++;
    end
  endtask
`endif

  initial begin : main
    rst = 1'b1; tx_dv = 1'b0; tx_word = '0; tx_count = '0;
    test_reset();
    test_full_word();
    test_short_word();
    test_count_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_word_ctrl.md
Name: spi_word_ctrl

Overview:
- Transaction controller directly upstream of SPI_Master.
- Accepts one multi-byte word (default 64 bits, one ASCON state lane) and asserts chip-select.
- Feeds SPI_Master one byte per handshake, MSB-first, and collects each received byte into a returned word.
- Releases chip-select after the last byte and enforces a minimum CS-high gap before accepting the next word.

Parameters:
- WORD_BYTES, 8, bytes per word; word width = 8*WORD_BYTES.
- CS_LEAD_CLKS, 2, i_Clk cycles between CS assert and first byte issue (min 1).
- CS_GAP_CLKS, 4, i_Clk cycles CS held high after a transaction before o_TX_Ready returns (min 1).
- TIMEOUT_CLKS, 255, per-byte watchdog limit; used only with SPI_CTRL_TIMEOUT_EN.

Ports:
- i_Clk  in  1  system clock (single clock domain).
- i_Rst  in  1  synchronous, active-high reset.
- i_TX_Word  in  8*WORD_BYTES  word to transmit.
- i_TX_Count  in  $clog2(WORD_BYTES+1)  bytes to send, 1..WORD_BYTES; 0 means WORD_BYTES.
- i_TX_DV  in  1  one-cycle pulse; qualifies i_TX_Word and i_TX_Count.
- o_TX_Ready  out  1  high when a new word may be accepted.
- o_RX_Word  out  8*WORD_BYTES  received word.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Word is valid.
- o_Timeout  out  1  one-cycle pulse on watchdog abort.
- o_M_TX_Byte  out  8  to SPI_Master i_TX_Byte.
- o_M_TX_DV  out  1  to SPI_Master i_TX_DV.
- i_M_TX_Ready  in  1  from SPI_Master o_TX_Ready.
- i_M_RX_DV  in  1  from SPI_Master o_RX_DV.
- i_M_RX_Byte  in  8  from SPI_Master o_RX_Byte.
- o_SPI_CS_n  out  1  active-low chip select.

Behaviour:
- Reset values: o_TX_Ready=1, o_SPI_CS_n=1, o_M_TX_DV=0, o_M_TX_Byte=0, o_RX_Word=0, o_RX_DV=0, o_Timeout=0; FSM in IDLE; counters cleared.
- Reset asserted mid-transaction: all of the above apply on the same clock edge; CS rises that edge; any in-flight byte is abandoned.
- States: IDLE, LEAD, ISSUE, WAIT_RX, WAIT_RDY, GAP.
- IDLE: o_TX_Ready=1. On i_TX_DV:
  - Latch N = (i_TX_Count==0 ? WORD_BYTES : i_TX_Count).
  - Load shift register with i_TX_Word << 8*(WORD_BYTES-N), so the N low bytes go out, most significant first.
  - Clear the RX accumulator.
  - Go to LEAD. Next cycle: o_TX_Ready=0, o_SPI_CS_n=0.
- LEAD: count CS_LEAD_CLKS cycles, then go to ISSUE.
- ISSUE: when i_M_TX_Ready=1, drive o_M_TX_Byte = shift-register top byte and pulse o_M_TX_DV for exactly one cycle; shift the register left 8; go to WAIT_RX. While i_M_TX_Ready=0, stay in ISSUE with no pulse.
- WAIT_RX: on i_M_RX_DV, rx_acc <= {rx_acc[8*WORD_BYTES-9:0], i_M_RX_Byte} and increment the byte count.
  - If count reaches N: go to GAP, set o_SPI_CS_n=1, load o_RX_Word=rx_acc(final), pulse o_RX_DV for one cycle.
  - Otherwise go to WAIT_RDY.
- WAIT_RDY: wait for i_M_TX_Ready=1, then go to ISSUE. CS stays low for the whole multi-byte transaction.
- GAP: CS high for CS_GAP_CLKS cycles, then IDLE with o_TX_Ready=1.
- Received bytes land LSB-aligned; unused upper bytes of o_RX_Word are 0.
- i_TX_DV while o_TX_Ready=0 is ignored with no side effects.
- i_M_RX_DV outside WAIT_RX is ignored.
- o_RX_Word holds its value until the next transaction completes.

Optional Feature:
- Macro SPI_CTRL_TIMEOUT_EN.
- Defined:
  - A watchdog counter restarts on every o_M_TX_DV pulse and runs in WAIT_RX.
  - If it reaches TIMEOUT_CLKS without i_M_RX_DV, pulse o_Timeout for one cycle, raise CS, skip o_RX_DV, and enter GAP.
  - o_RX_Word is left unchanged.
- Not defined: no watchdog logic; o_Timeout tied to 0; WAIT_RX waits indefinitely.

Test Plan:
Common setup: SPI_Master with SPI_MODE=3, CLKS_PER_HALF_BIT=4, MOSI looped to MISO, defaults unless noted.
- Full word: i_TX_Word=64'h0123456789ABCDEF, count 8 -> bytes 01,23,…,EF on o_M_TX_Byte in order; 8 o_M_TX_DV pulses; CS low continuously; o_RX_Word=64'h0123456789ABCDEF; one o_RX_DV pulse.
- Short word: i_TX_Word=64'hFFFFFFFFFFFFBEEF, count 2 -> only BE then EF sent; o_RX_Word=64'h000000000000BEEF.
- Count 0: i_TX_Word=64'hC1C2C3C4C5C6C7C8, count 0 -> 8 bytes sent; o_RX_Word equals input.
- Busy/back-to-back: second i_TX_DV (64'hAA…) during busy -> ignored. New DV right after o_TX_Ready rises -> accepted, with CS high ≥4 cycles between transactions.
- Reset mid-transfer: assert i_Rst after the 3rd byte issue -> next edge CS=1, o_TX_Ready=1, no o_RX_DV. A following 1-byte 8'h5A transaction returns 64'h5A.
- Timeout (macro defined, TIMEOUT_CLKS=20, stub master never pulses i_M_RX_DV) -> o_Timeout pulses 20 cycles after o_M_TX_DV; CS rises; no o_RX_DV.
